// File: rtl/l2_port_arbiter.sv
// Shares the L2 request port between I-cache and D-cache, one tenure per valid, round-robin on contention.
// One-cycle grant; fulfilled is combinational; the non-owner is held off until the owner drops valid.
package l2_port_arbiter_pkg;
  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
endpackage

module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  memory_operation_e i_req_type,
  input  logic [ADDR_W-1:0] i_req_address,
  output logic              i_req_fulfilled,
  input  logic              d_req_valid,
  input  memory_operation_e d_req_type,
  input  logic [ADDR_W-1:0] d_req_address,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_fulfilled,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  output logic [ADDR_W-1:0] l2_req_address,
  output logic [DATA_W-1:0] l2_req_wdata,
  input  logic              l2_req_fulfilled,
  output logic              owner_is_d,
  output logic              beat_overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT_I, ST_GRANT_D} state_e;

  localparam int CNT_W = $clog2(MAX_BEATS + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

  state_e           state;
  state_e           state_nxt;
  logic             last_owner;
  logic [CNT_W-1:0] beat_cnt;
  logic             owner_beat;
  logic             grant_entry;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_req_valid && d_req_valid) state_nxt = last_owner ? ST_GRANT_I : ST_GRANT_D;
        else if (i_req_valid)           state_nxt = ST_GRANT_I;
        else if (d_req_valid)           state_nxt = ST_GRANT_D;
      end
      ST_GRANT_I: begin
        if (!i_req_valid) state_nxt = d_req_valid ? ST_GRANT_D : ST_IDLE;
      end
      ST_GRANT_D: begin
        if (!d_req_valid) state_nxt = i_req_valid ? ST_GRANT_I : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    l2_req_valid   = 1'b0;
    l2_req_type    = LOAD;
    l2_req_address = '0;
    l2_req_wdata   = '0;
    case (state)
      ST_GRANT_I: begin
        l2_req_valid   = i_req_valid;
        l2_req_type    = i_req_type;
        l2_req_address = i_req_address;
      end
      ST_GRANT_D: begin
        l2_req_valid   = d_req_valid;
        l2_req_type    = d_req_type;
        l2_req_address = d_req_address;
        l2_req_wdata   = d_req_wdata;
      end
      default: ;
    endcase
  end

  assign i_req_fulfilled = l2_req_fulfilled && (state == ST_GRANT_I) && i_req_valid;
  assign d_req_fulfilled = l2_req_fulfilled && (state == ST_GRANT_D) && d_req_valid;
  assign owner_beat      = i_req_fulfilled || d_req_fulfilled;
  // Entry never coincides with an owner beat: it happens only from idle or on a valid-low release.
  assign grant_entry     = (state_nxt != state) && (state_nxt != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      last_owner   <= 1'b1;
      beat_cnt     <= '0;
      owner_is_d   <= 1'b0;
      beat_overrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner_is_d <= (state_nxt == ST_GRANT_D);
      if (grant_entry) begin
        last_owner <= (state_nxt == ST_GRANT_D);
        beat_cnt   <= '0;
      end else if (owner_beat && (beat_cnt != CNT_SAT)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (owner_beat && (beat_cnt >= CNT_MAX)) beat_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: a tenure-level model predicts each cycle's outputs.
module tb_l2_port_arbiter;
  import l2_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_req_valid = 1'b0;
  memory_operation_e i_req_type = LOAD;
  logic [AW-1:0]     i_req_address = '0;
  logic              i_req_fulfilled;
  logic              d_req_valid = 1'b0;
  memory_operation_e d_req_type = LOAD;
  logic [AW-1:0]     d_req_address = '0;
  logic [DW-1:0]     d_req_wdata = '0;
  logic              d_req_fulfilled;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic [AW-1:0]     l2_req_address;
  logic [DW-1:0]     l2_req_wdata;
  logic              l2_req_fulfilled = 1'b0;
  logic              owner_is_d;
  logic              beat_overrun;

  always #5 clk = ~clk;

  l2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_type(i_req_type), .i_req_address(i_req_address),
    .i_req_fulfilled(i_req_fulfilled),
    .d_req_valid(d_req_valid), .d_req_type(d_req_type), .d_req_address(d_req_address),
    .d_req_wdata(d_req_wdata), .d_req_fulfilled(d_req_fulfilled),
    .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type), .l2_req_address(l2_req_address),
    .l2_req_wdata(l2_req_wdata), .l2_req_fulfilled(l2_req_fulfilled),
    .owner_is_d(owner_is_d), .beat_overrun(beat_overrun)
  );

  typedef struct {
    logic        l2v;
    logic        l2t;
    logic [31:0] l2a;
    logic [31:0] l2w;
    logic        ifl;
    logic        dfl;
    logic        own_d;
    logic        ovr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Tenure-level model: who owns the port (0 none, 1 I, 2 D), who wins the next tie, beats so far.
  int owner = 0;
  bit prefer_d = 1'b0;
  int beats = 0;
  bit ovr = 1'b0;
  bit rst_req = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic grant(input int who);
    owner    = who;
    beats    = 0;
    prefer_d = (who == 1);
  endtask

  task automatic step(input bit iv, input bit it, input logic [31:0] ia,
                      input bit dv, input bit dt, input logic [31:0] da,
                      input logic [31:0] dw, input bit f);
    exp_t e;
    @(posedge clk); #1;
    i_req_valid = iv; i_req_type = memory_operation_e'(it); i_req_address = ia;
    d_req_valid = dv; d_req_type = memory_operation_e'(dt); d_req_address = da;
    d_req_wdata = dw; l2_req_fulfilled = f;
    reset = ~rst_req;
    e = '{l2v: 1'b0, l2t: 1'b0, l2a: 32'd0, l2w: 32'd0, ifl: 1'b0, dfl: 1'b0, own_d: 1'b0, ovr: 1'b0};
    if (rst_req) begin
      owner = 0; beats = 0; ovr = 1'b0; prefer_d = 1'b0;
      #1;
      chk("reset_l2_valid", l2_req_valid, 0);
      chk("reset_owner_is_d", owner_is_d, 0);
      chk("reset_overrun", beat_overrun, 0);
    end else begin
      if (owner == 1) begin
        e.l2v = iv; e.l2t = it; e.l2a = ia; e.ifl = iv && f;
      end else if (owner == 2) begin
        e.l2v = dv; e.l2t = dt; e.l2a = da; e.l2w = dw; e.dfl = dv && f;
      end
      e.own_d = (owner == 2);
      e.ovr   = ovr;
      if (e.ifl || e.dfl) begin
        beats++;
        if (beats > MB) ovr = 1'b1;
      end
      if (owner == 0) begin
        if (iv && dv) grant(prefer_d ? 2 : 1);
        else if (iv)  grant(1);
        else if (dv)  grant(2);
      end else if (owner == 1 && !iv) begin
        if (dv) grant(2); else owner = 0;
      end else if (owner == 2 && !dv) begin
        if (iv) grant(1); else owner = 0;
      end
    end
    sb.push_back(e);
  endtask

  task automatic s(input bit iv, input bit dv, input bit f);
    step(iv, 1'b0, $urandom, dv, 1'b0, $urandom, $urandom, f);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    s(0, 0, 0);
    s(0, 0, 0);
    rst_req = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("l2_req_valid", l2_req_valid, e.l2v);
        chk("l2_req_type", l2_req_type, e.l2t);
        chk("l2_req_address", l2_req_address, e.l2a);
        chk("l2_req_wdata", l2_req_wdata, e.l2w);
        chk("i_req_fulfilled", i_req_fulfilled, e.ifl);
        chk("d_req_fulfilled", d_req_fulfilled, e.dfl);
        chk("owner_is_d", owner_is_d, e.own_d);
        chk("beat_overrun", beat_overrun, e.ovr);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit iv, dv, it, dt;
    do_reset();

    // I alone: four-beat fill.
    s(1, 0, 0);
    repeat (4) s(1, 0, 1);
    s(0, 0, 1);
    repeat (2) s(0, 0, 0);

    // Simultaneous request after reset: I first, then D with no bubble.
    do_reset();
    s(1, 1, 0);
    repeat (3) s(1, 1, 1);
    s(0, 1, 0);
    repeat (2) s(0, 1, 1);
    s(0, 0, 0);
    s(0, 0, 0);

    // D write-back then allocate with valid continuous, I waiting.
    do_reset();
    s(0, 1, 0);
    repeat (4) step(1, 0, 32'h100, 1, 1, 32'h2000, 32'hDEADBEEF, 1);
    repeat (4) step(1, 0, 32'h100, 1, 0, 32'h2040, 32'hDEADBEEF, 1);
    s(1, 0, 0);
    repeat (2) s(1, 0, 1);
    s(0, 0, 0);
    s(0, 0, 0);

    // Nine beats in one tenure, then release; flag must stay set.
    do_reset();
    s(1, 0, 0);
    repeat (MB + 1) s(1, 0, 1);
    s(0, 0, 0);
    repeat (3) s(0, 0, 1);

    // Reset mid-burst of a D tenure, then a tie goes to I.
    do_reset();
    s(0, 1, 0);
    repeat (2) s(0, 1, 1);
    rst_req = 1'b1;
    s(0, 1, 1);
    s(0, 1, 0);
    rst_req = 1'b0;
    s(1, 1, 0);
    s(1, 1, 1);
    s(0, 0, 0);
    s(0, 0, 0);

    // Fulfilled while nothing is driven to L2.
    do_reset();
    repeat (2) s(0, 0, 1);
    s(1, 0, 0);
    s(1, 0, 1);
    s(0, 0, 1);
    s(0, 0, 1);

    // Random traffic with hold-biased valids and occasional resets.
    iv = 1'b0; dv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (iv) iv = ($urandom_range(0, 5) != 0); else iv = ($urandom_range(0, 2) == 0);
      if (dv) dv = ($urandom_range(0, 5) != 0); else dv = ($urandom_range(0, 2) == 0);
      it = $urandom_range(0, 1);
      dt = $urandom_range(0, 1);
      rst_req = ($urandom_range(0, 299) == 0);
      step(iv, it, $urandom, dv, dt, $urandom, $urandom, $urandom_range(0, 1) == 1);
    end
    rst_req = 1'b0;
    s(0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Two-requester arbiter sharing the single L2 request port between the instruction-cache controller (port I) and the data-cache controller (port D). A requester owns the L2 port from grant until it drops its request valid, so a multi-beat line fill or a write-back-then-allocate sequence is never interleaved with the other cache's traffic. Ownership after contention alternates round-robin. A per-tenure beat counter flags any requester that overruns its line length.

## Interface
- `ADDR_W`, 32: request address width.
- `DATA_W`, 32: store/load data width.
- `MAX_BEATS`, 8: maximum fulfilled beats permitted in one tenure.

- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_req_valid` in 1: I-cache request valid.
- `i_req_type` in memory_operation_e: I-cache request type.
- `i_req_address` in ADDR_W: I-cache request address.
- `i_req_fulfilled` out 1: I-cache beat complete.
- `d_req_valid` in 1: D-cache request valid.
- `d_req_type` in memory_operation_e: D-cache request type.
- `d_req_address` in ADDR_W: D-cache request address.
- `d_req_wdata` in DATA_W: D-cache store data.
- `d_req_fulfilled` out 1: D-cache beat complete.
- `l2_req_valid` out 1: request valid toward L2.
- `l2_req_type` out memory_operation_e: forwarded type.
- `l2_req_address` out ADDR_W: forwarded address.
- `l2_req_wdata` out DATA_W: forwarded store data; 0 while I owns.
- `l2_req_fulfilled` in 1: L2 beat complete.
- `owner_is_d` out 1: 1 when D owns the port, 0 when I owns it or the port is idle.
- `beat_overrun` out 1: sticky error, tenure exceeded MAX_BEATS.

## Operation
- States: ST_IDLE, ST_GRANT_I, ST_GRANT_D. There is also a `last_owner` register, where 0 means I and 1 means D.
- ST_IDLE:
  - Only I valid -> ST_GRANT_I.
  - Only D valid -> ST_GRANT_D.
  - Both valid -> grant the requester opposite `last_owner`.
  - Neither valid -> stay in ST_IDLE.
- ST_GRANT_x while the owner's valid is 1 -> stay in ST_GRANT_x. The owner may change type, address or data between beats, for example a write-back STORE burst followed by a LOAD burst.
- ST_GRANT_x while the owner's valid is 0 (release):
  - If the other requester's valid is 1, go directly to ST_GRANT_other with no idle bubble.
  - Otherwise go to ST_IDLE.
- `last_owner` updates on every entry to a GRANT state.
- Outputs, decoded from state:
  - `l2_req_valid` = owner's valid while in a GRANT state, 0 in ST_IDLE.
  - `l2_req_type`, `l2_req_address` and `l2_req_wdata` mux from the owner. In ST_IDLE they drive LOAD, 0 and 0.
  - `x_req_fulfilled` = `l2_req_fulfilled` AND (state == ST_GRANT_x) AND `x_req_valid`. The non-owner always sees 0.
- Beat counter:
  - Clears to 0 on every entry to a GRANT state.
  - Increments on each owner fulfilled beat and saturates at MAX_BEATS+1.
  - `beat_overrun` sets when a fulfilled beat arrives with the count already at MAX_BEATS, and stays set until reset.
- `l2_req_fulfilled` while `l2_req_valid` is 0 is ignored. It does not change the counter or any fulfilled output.
- Reset (asynchronous, any time, including mid-burst):
  - State -> ST_IDLE, `last_owner` -> 1, so I wins the first contention.
  - Beat counter and `beat_overrun` -> 0.
  - Every output -> 0 (`l2_req_type` = LOAD).

## Timing
- Arbitration latency is one cycle: a valid seen in ST_IDLE at edge N produces `l2_req_valid` from edge N+1.
- Handover on release costs zero idle cycles: the owner drops valid in cycle N and the other requester is driven to L2 in cycle N+1.
- Fulfilled is combinational from `l2_req_fulfilled`, so the requester sees it in the same cycle.
- `owner_is_d` and `beat_overrun` are registered. `beat_overrun` asserts the cycle after the offending beat.
- A requester never loses the grant while holding valid. Starvation is bounded by the other requester's tenure.

## Test plan
- I alone does a 4-beat fill (valid held, fulfilled on 4 cycles, then valid drops) -> `l2_req_valid` is 1 on cycles 1–4 after request, `i_req_fulfilled` pulses 4 times, state returns to ST_IDLE, `owner_is_d` = 0 throughout.
- I and D raise valid in the same cycle after reset -> I granted first. D is granted the cycle after I drops valid, with no idle cycle, and `owner_is_d` goes to 1.
- D does a write-back (STORE, `d_req_wdata` = 0xDEADBEEF, 4 beats) and then a LOAD allocate with valid continuous, while I waits -> I stays ungranted until D releases, and `i_req_fulfilled` stays 0 throughout.
- With `MAX_BEATS` = 8, the owner receives 9 fulfilled beats in one tenure -> `beat_overrun` = 1 from the cycle after beat 9 and stays set after release.
- Reset (low) mid-burst at beat 2 of a D tenure -> all outputs 0 immediately, state is ST_IDLE, and on a later simultaneous I/D request I is granted.
- `l2_req_fulfilled` pulsed in ST_IDLE and during an owner valid-low cycle -> no fulfilled output, beat count unchanged.
